// File: rtl/i2c_read_capture.sv
// Passive I2C read monitor: synchronizes and glitch-filters SCL/SDA, tracks bus
// conditions and captures the read bytes of an NBYTES-byte sensor frame.
module i2c_read_capture #(
    parameter int FILT   = 3,
    parameter int NBYTES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic                  busy,
    output logic [6:0]            addr,
    output logic [7:0]            rx_data,
    output logic [2:0]            rx_idx,
    output logic                  rx_valid,
    output logic [8*NBYTES-1:0]   frame,
    output logic                  frame_valid,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int         CW   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [2:0] LAST = 3'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, SKIP} state_t;

    logic [1:0]          scl_sync, sda_sync;
    logic                scl_f, sda_f, scl_fd, sda_fd;
    logic [CW-1:0]       scl_cnt, sda_cnt;
    logic                scl_rise, sda_fall, sda_rise, start_evt, stop_evt;
    state_t              state;
    logic [2:0]          bit_cnt, byte_cnt;
    logic [7:0]          shift, shift_next;
    logic [6:0]          addr_pend;
    logic                rw;
    logic [8*NBYTES-1:0] frame_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

    // A filtered level only follows the synchronized input after FILT
    // consecutive samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_sync[1] != scl_f) begin
            if (scl_cnt == CW'(FILT - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
        end else begin
            scl_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_sync[1] != sda_f) begin
            if (sda_cnt == CW'(FILT - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end else begin
            sda_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_fd <= 1'b1;
            sda_fd <= 1'b1;
        end else begin
            scl_fd <= scl_f;
            sda_fd <= sda_f;
        end
    end

    always_comb begin
        scl_rise   = scl_f & ~scl_fd;
        sda_fall   = ~sda_f & sda_fd;
        sda_rise   = sda_f & ~sda_fd;
        start_evt  = sda_fall & scl_f;
        stop_evt   = sda_rise & scl_f;
        shift_next = {shift[6:0], sda_f};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            addr        <= '0;
            rx_data     <= '0;
            rx_idx      <= '0;
            rx_valid    <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shift       <= '0;
            addr_pend   <= '0;
            rw          <= 1'b0;
            frame_buf   <= '0;
        end else begin
            rx_valid    <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (start_evt) begin
                if (state == DATA || state == DATA_ACK) begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                end
                state     <= ADDR;
                busy      <= 1'b1;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                shift     <= '0;
                frame_buf <= '0;
            end else if (stop_evt) begin
                if (state == DATA || state == DATA_ACK) begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                end
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    ADDR: begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr_pend <= shift_next[7:1];
                            rw        <= shift_next[0];
                            state     <= ADDR_ACK;
                        end
                    end
                    // addr only takes an address the slave actually acknowledged
                    ADDR_ACK: begin
                        if (!sda_f) begin
                            addr <= addr_pend;
                            if (rw) begin
                                byte_cnt <= '0;
                                state    <= DATA;
                            end else begin
                                state <= SKIP;
                            end
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= SKIP;
                        end
                    end
                    DATA: begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= shift_next;
                            rx_idx   <= byte_cnt;
                            rx_valid <= 1'b1;
                            for (int unsigned i = 0; i < NBYTES; i++)
                                if (byte_cnt == 3'(i))
                                    frame_buf[8*(NBYTES-1-i) +: 8] <= shift_next;
                            state <= DATA_ACK;
                        end
                    end
                    DATA_ACK: begin
                        if (!sda_f) begin
                            if (byte_cnt == LAST) begin
                                err      <= 1'b1;
                                err_code <= 2'b11;
                                state    <= SKIP;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                                state    <= DATA;
                            end
                        end else if (byte_cnt == LAST) begin
                            frame       <= frame_buf;
                            frame_valid <= 1'b1;
                            state       <= SKIP;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            state    <= SKIP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_read_capture.sv
// Directed bench for i2c_read_capture: bit-banged bus sequences with
// hand-computed byte, frame and error expectations.
module tb_i2c_read_capture;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda = 1'b1;
    logic        busy;
    logic [6:0]  addr;
    logic [7:0]  rx_data;
    logic [2:0]  rx_idx;
    logic        rx_valid;
    logic [47:0] frame;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    int         rxn = 0, fvn = 0, errn = 0;
    logic [7:0] rxd [0:63];
    logic [2:0] rxi [0:63];
    int         rb, fb, eb;

    i2c_read_capture #(.FILT(3), .NBYTES(6)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .busy(busy), .addr(addr),
        .rx_data(rx_data), .rx_idx(rx_idx), .rx_valid(rx_valid), .frame(frame),
        .frame_valid(frame_valid), .err(err), .err_code(err_code)
    );

    always #10 clk = ~clk;

    // Strobe logger: each strobe lasts one cycle, so sampling 1 ns after the edge sees it once.
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            if (rxn < 64) begin
                rxd[rxn] = rx_data;
                rxi[rxn] = rx_idx;
            end
            rxn++;
        end
        if (frame_valid) fvn++;
        if (err) errn++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sda = 1'b0; wait_n(Q);
        scl = 1'b0; wait_n(Q);
    endtask

    task automatic bus_rstart;
        sda = 1'b1; wait_n(Q);
        scl = 1'b1; wait_n(Q);
        sda = 1'b0; wait_n(Q);
        scl = 1'b0; wait_n(Q);
    endtask

    task automatic bus_stop;
        sda = 1'b0; wait_n(Q);
        scl = 1'b1; wait_n(Q);
        sda = 1'b1; wait_n(Q);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda = b;
        if (glitch) begin
            wait_n(2);
            scl = 1'b1; wait_n(2);
            scl = 1'b0;
        end
        wait_n(Q);
        scl = 1'b1; wait_n(Q);
        scl = 1'b0; wait_n(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && i == 5);
    endtask

    task automatic full_read(input logic [47:0] d, input bit glitch);
        bus_start;
        send_byte(8'hA0, 1'b0); send_bit(1'b0, 1'b0);
        send_byte(8'h3B, 1'b0); send_bit(1'b0, 1'b0);
        bus_rstart;
        send_byte(8'hA1, 1'b0); send_bit(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send_byte(d[47-8*k -: 8], glitch && k == 0);
            send_bit(k == 5, 1'b0);
        end
        wait_n(10);
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [47:0] d);
        check({tag, "_rx_count"}, 64'(rxn - rb), 64'(n));
        for (int k = 0; k < n; k++) begin
            check({tag, "_rx_data"}, 64'(rxd[rb+k]), 64'(d[47-8*k -: 8]));
            check({tag, "_rx_idx"}, 64'(rxi[rb+k]), 64'(k));
        end
    endtask

    task automatic snap;
        rb = rxn; fb = fvn; eb = errn;
    endtask

    initial begin
        wait_n(4);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_addr", 64'(addr), 64'd0);
        check("reset_rx_data", 64'(rx_data), 64'd0);
        check("reset_frame", 64'(frame), 64'd0);
        check("reset_strobes", 64'({rx_valid, frame_valid, err}), 64'd0);
        check("reset_err_code", 64'(err_code), 64'd0);
        rst = 1'b0;
        wait_n(10);

        // write-only transaction
        snap;
        bus_start;
        send_byte(8'hA0, 1'b0); send_bit(1'b0, 1'b0);
        send_byte(8'h3B, 1'b0); send_bit(1'b0, 1'b0);
        check("wr_busy_high", 64'(busy), 64'd1);
        bus_stop;
        wait_n(10);
        check("wr_busy_low", 64'(busy), 64'd0);
        check("wr_addr", 64'(addr), 64'h50);
        check("wr_no_rx", 64'(rxn - rb), 64'd0);
        check("wr_no_frame", 64'(fvn - fb), 64'd0);
        check("wr_no_err", 64'(errn - eb), 64'd0);

        // full read
        snap;
        full_read(48'h123456789ABC, 1'b0);
        check_bytes("read1", 6, 48'h123456789ABC);
        check("read1_frame_valid", 64'(fvn - fb), 64'd1);
        check("read1_frame", 64'(frame), 64'h123456789ABC);
        check("read1_addr", 64'(addr), 64'h50);
        check("read1_busy", 64'(busy), 64'd1);
        bus_stop;
        wait_n(10);
        check("read1_no_err", 64'(errn - eb), 64'd0);
        check("read1_busy_low", 64'(busy), 64'd0);

        // address NACK
        snap;
        bus_start;
        send_byte(8'hA1, 1'b0); send_bit(1'b1, 1'b0);
        wait_n(4);
        check("nack_err", 64'(errn - eb), 64'd1);
        check("nack_code", 64'(err_code), 64'd1);
        send_byte(8'h5A, 1'b0); send_bit(1'b0, 1'b0);
        bus_stop;
        wait_n(10);
        check("nack_no_rx", 64'(rxn - rb), 64'd0);
        check("nack_err_once", 64'(errn - eb), 64'd1);

        // short frame: master NACKs after the third byte
        snap;
        bus_start;
        send_byte(8'hA1, 1'b0); send_bit(1'b0, 1'b0);
        send_byte(8'h11, 1'b0); send_bit(1'b0, 1'b0);
        send_byte(8'h22, 1'b0); send_bit(1'b0, 1'b0);
        send_byte(8'h33, 1'b0); send_bit(1'b1, 1'b0);
        wait_n(10);
        check_bytes("short", 3, 48'h112233000000);
        check("short_err", 64'(errn - eb), 64'd1);
        check("short_code", 64'(err_code), 64'd2);
        check("short_no_frame", 64'(fvn - fb), 64'd0);
        check("short_frame_kept", 64'(frame), 64'h123456789ABC);
        bus_stop;
        wait_n(10);
        check("short_stop_no_err", 64'(errn - eb), 64'd1);

        // glitches: 1-cycle SDA dip on idle bus, then a 2-cycle SCL pulse inside a byte
        snap;
        sda = 1'b0; wait_n(1);
        sda = 1'b1; wait_n(20);
        check("glitch_no_start", 64'(busy), 64'd0);
        full_read(48'hDEADBEEF0180, 1'b1);
        check_bytes("glitch", 6, 48'hDEADBEEF0180);
        check("glitch_frame", 64'(frame), 64'hDEADBEEF0180);
        check("glitch_no_err", 64'(errn - eb), 64'd0);
        bus_stop;
        wait_n(10);

        // reset in the middle of a data byte
        bus_start;
        send_byte(8'hA1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_frame", 64'(frame), 64'd0);
        check("rst_rx", 64'({rx_data, rx_idx}), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        wait_n(3);
        rst = 1'b0;
        snap;
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_byte(8'h34, 1'b0); send_bit(1'b0, 1'b0);
        wait_n(10);
        check("post_rst_no_rx", 64'(rxn - rb), 64'd0);
        check("post_rst_idle", 64'(busy), 64'd0);
        bus_stop;
        wait_n(10);
        check("post_rst_no_err", 64'(errn - eb), 64'd0);
        snap;
        full_read(48'hC0FFEE0055AA, 1'b0);
        check_bytes("read2", 6, 48'hC0FFEE0055AA);
        check("read2_frame_valid", 64'(fvn - fb), 64'd1);
        check("read2_frame", 64'(frame), 64'hC0FFEE0055AA);
        check("read2_addr", 64'(addr), 64'h50);
        bus_stop;
        wait_n(10);
        check("read2_no_err", 64'(errn - eb), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_read_capture.md
Name: i2c_read_capture

Overview:
- Passive I2C bus monitor placed directly downstream of the I2C master controller.
- Watches the resolved SCL/SDA lines and detects START, repeated START and STOP conditions.
- Decodes the address byte and deserializes the read-data bytes that the slave returns after a repeated START.
- Presents each byte as a one-cycle strobe, and presents the complete NBYTES-byte sensor frame as one packed word for the processing logic.

Parameters:
- FILT, 3: number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (glitch filter).
- NBYTES, 6: number of read bytes in one complete frame.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  resolved SCL bus level.
- sda  input  1  resolved SDA bus level (wired value: master drive or slave drive).
- busy  output  1  high between a START and the following STOP.
- addr  output  7  7-bit address of the last acknowledged address byte.
- rx_data  output  8  last received read byte.
- rx_idx  output  3  index (0..NBYTES-1) of rx_data within the frame.
- rx_valid  output  1  one-cycle strobe: rx_data/rx_idx updated.
- frame  output  8*NBYTES  last complete frame; byte 0 in the MSBs.
- frame_valid  output  1  one-cycle strobe: frame updated.
- err  output  1  one-cycle error strobe.
- err_code  output  2  cause of last err: 01 address NACK, 10 short frame, 11 overrun; holds until the next err.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; all outputs 0.
  - Synchronizer and filter registers set to 1 (idle bus).
  - Bit and byte counters 0; shift register 0.
- Input path:
  - 2-FF synchronizer on scl and sda.
  - Filtered level toggles after FILT consecutive differing samples.
  - Edge flags are one-cycle pulses derived from the filtered levels.
- Bus events:
  - START: filtered sda falls while filtered scl = 1.
  - STOP: filtered sda rises while filtered scl = 1.
  - Data bits are sampled on the filtered scl rising edge, MSB first.
- All output strobes assert on the cycle after the filtered edge that causes them.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After bit 8, latch addr = bits[7:1] and rw = bit[0]; go to ADDR_ACK.
  - ADDR_ACK:
    - Sampled bit 0 with rw=1: addr updated, byte_cnt=0, go to DATA.
    - Sampled bit 0 with rw=0: go to SKIP.
    - Sampled bit 1: err, err_code=01, go to SKIP.
  - DATA: shift 8 bits. After bit 8: rx_data=byte, rx_idx=byte_cnt, rx_valid pulse, store byte into frame buffer slot byte_cnt; go to DATA_ACK.
  - DATA_ACK (master's acknowledge bit):
    - ACK (0) with byte_cnt < NBYTES-1: byte_cnt+1, go to DATA.
    - ACK with byte_cnt = NBYTES-1: err, err_code=11, go to SKIP.
    - NACK (1) with byte_cnt = NBYTES-1: copy buffer to frame, frame_valid pulse, go to SKIP.
    - NACK earlier: err, err_code=10, go to SKIP.
  - SKIP: ignore bits until START or STOP.
- START in any state (repeated START included):
  - Go to ADDR.
  - Clear bit counter, byte_cnt and shift register.
  - Partial frame buffer is discarded.
  - No error is raised, except in DATA/DATA_ACK, which raises err, err_code=10.
- STOP in any state: go to IDLE, busy=0.
  - STOP in DATA or DATA_ACK also raises err, err_code=10.
- busy: set on the cycle after START, cleared on the cycle after STOP.
- frame changes only on frame_valid. rx_valid, frame_valid and err never assert in the same cycle except rx_valid alone.
- SCL edges while in IDLE are ignored. A frame that ends without STOP (master holds SDA low) is still complete at the final NACK.
- Reset mid-transaction: immediate return to reset values. The first post-reset event is accepted only after a fresh START.

Test Plan:
- Full read: START, 0xA0+ACK, reg 0x3B+ACK, repeated START, 0xA1+ACK, bytes 0x12 0x34 0x56 0x78 0x9A 0xBC with ACK×5 then NACK → six rx_valid strobes with rx_idx 0..5 and matching rx_data; addr=0x50; then one frame_valid with frame=0x123456789ABC and no err.
- Write-only transaction (0xA0, reg byte, STOP) → addr=0x50, no rx_valid, no frame_valid, busy 1→0.
- Address 0xA1 NACKed → err pulse, err_code=01; later data bits produce no rx_valid.
- NACK after third byte (0x11 0x22 0x33) → three rx_valid, err with err_code=10; frame still holds 0x123456789ABC from the previous test.
- Glitch: 1-cycle sda low pulse while scl high, FILT=3 → no START, busy stays 0. Then 2-cycle scl high glitch during DATA → no extra bit sampled; the byte decodes correctly.
- rst asserted mid-byte of DATA → all outputs 0 immediately; bits before a new START are ignored; the next full read yields a correct frame.
